// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int FRAME_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    RALLY,
    POINT_PAUSE,
    GAME_OVER
  } match_state_t;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_P1   = 2'b01;
  localparam logic [1:0] WHO_P2   = 2'b10;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/match_control_frame_timer.sv
// Frame counter: counts end_of_frame ticks since the last clear, saturating at its maximum.
module frame_timer
  import pong_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic [FRAME_W-1:0] limit_i,
  output logic               done_o
);

  logic [FRAME_W-1:0] cnt_q;
  logic [FRAME_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != {FRAME_W{1'b1}})) begin
      cnt_d = cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q >= limit_i);

endmodule

// File: rtl/match_control.sv
// Pong match sequencer: mode select, serve pulses, scoring and winner declaration.
// Optional auto-serve is enabled by defining MATCH_CONTROL_AUTO_SERVE_EN.
module match_control
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned AUTO_FRAMES  = 120
) (
  input  logic               clk65MHz,
  input  logic               rst,
  input  logic               end_of_frame,
  input  logic               btn_start,
  input  logic               btn_mode,
  input  logic               btn_serve,
  input  logic               scored_p1,
  input  logic               scored_p2,
  output logic               serve,
  output logic               server,
  output logic               screen_idle,
  output logic               screen_multi,
  output logic [SCORE_W-1:0] points_player_1,
  output logic [SCORE_W-1:0] points_player_2,
  output logic [1:0]         who_won
);

  match_state_t       state_q, state_d;
  logic               mode_q, mode_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic [1:0]         who_q, who_d;
  logic               server_q, server_d;
  logic               serve_q, serve_d;
  logic               idle_q, multi_q;

  logic               start_s_q, start_p_q;
  logic               srv_s_q, srv_p_q;
  logic               start_edge, serve_edge;

  logic [FRAME_W-1:0] limit;
  logic               timer_clear;
  logic               timer_done;

  // Buttons track their level during reset so a button held through reset yields no edge.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      start_s_q <= btn_start;
      start_p_q <= btn_start;
      srv_s_q   <= btn_serve;
      srv_p_q   <= btn_serve;
    end else begin
      start_s_q <= btn_start;
      start_p_q <= start_s_q;
      srv_s_q   <= btn_serve;
      srv_p_q   <= srv_s_q;
    end
  end

  assign start_edge = start_s_q & ~start_p_q;
  assign serve_edge = srv_s_q & ~srv_p_q;

  always_comb begin
    limit = {FRAME_W{1'b1}};
    case (state_q)
      SERVE_WAIT:  limit = FRAME_W'(AUTO_FRAMES);
      POINT_PAUSE: limit = FRAME_W'(PAUSE_FRAMES);
      GAME_OVER:   limit = FRAME_W'(OVER_FRAMES);
      default:     limit = {FRAME_W{1'b1}};
    endcase
  end

  assign timer_clear = (state_d != state_q);

  frame_timer u_frame_timer (
    .clk_i   (clk65MHz),
    .rst_i   (rst),
    .clear_i (timer_clear),
    .tick_i  (end_of_frame),
    .limit_i (limit),
    .done_o  (timer_done)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    who_d    = who_q;
    server_d = server_q;
    serve_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = SERVE_WAIT;
          mode_d   = btn_mode;
          p1_d     = '0;
          p2_d     = '0;
          who_d    = WHO_NONE;
          server_d = 1'b0;
        end
      end
      SERVE_WAIT: begin
`ifdef MATCH_CONTROL_AUTO_SERVE_EN
        if (serve_edge || timer_done) begin
`else
        if (serve_edge) begin
`endif
          state_d = RALLY;
          serve_d = 1'b1;
        end
      end
      RALLY: begin
        // Simultaneous hits are a let: pause, but nobody scores and the server stays.
        if (scored_p1 && !scored_p2) begin
          p1_d     = score_inc(p1_q);
          server_d = ~server_q;
        end else if (scored_p2 && !scored_p1) begin
          p2_d     = score_inc(p2_q);
          server_d = ~server_q;
        end
        if (scored_p1 || scored_p2) begin
          state_d = POINT_PAUSE;
        end
      end
      POINT_PAUSE: begin
        if (timer_done) begin
          if (p1_q == SCORE_W'(WIN_SCORE)) begin
            state_d = GAME_OVER;
            who_d   = WHO_P1;
          end else if (p2_q == SCORE_W'(WIN_SCORE)) begin
            state_d = GAME_OVER;
            who_d   = WHO_P2;
          end else begin
            state_d = SERVE_WAIT;
          end
        end
      end
      GAME_OVER: begin
        if (timer_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Screen flags are derived from next state so they change together with state_q.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      who_q    <= WHO_NONE;
      server_q <= 1'b0;
      serve_q  <= 1'b0;
      idle_q   <= 1'b1;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      who_q    <= who_d;
      server_q <= server_d;
      serve_q  <= serve_d;
      idle_q   <= (state_d == IDLE);
      multi_q  <= mode_d && (state_d != IDLE);
    end
  end

  assign serve           = serve_q;
  assign server          = server_q;
  assign screen_idle     = idle_q;
  assign screen_multi    = multi_q;
  assign points_player_1 = p1_q;
  assign points_player_2 = p2_q;
  assign who_won         = who_q;

endmodule
